// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Parametrised multi-port general-purpose register file with a
//               per-register busy scoreboard and a sequential post-reset
//               clear engine (the storage array itself carries no reset).
//
//   Ports
//     i_clk       rising-edge clock
//     i_rst       synchronous, active-high reset
//     i_wr_en     per-port write enable             [NUM_WR]
//     i_wr_addr   write addresses, port k at [k*AW +: AW]
//     i_wr_data   write data, port k at [k*XLEN +: XLEN]
//     i_rd_addr   read addresses, port j at [j*AW +: AW]
//     o_rd_data   combinational read data, port j at [j*XLEN +: XLEN]
//     o_rd_busy   combinational busy flag per read port
//     i_issue_en  marks a new in-flight producer of i_issue_rd
//     i_issue_rd  destination register being issued
//     o_ready     high once the clear sequence has completed
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     When defined, a read whose address matches an active write in the same
//     cycle returns the write data (highest-index write port wins) and its
//     busy flag is forced low unless that register is issued the same cycle.
//
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_WR-1:0]      i_wr_en,
    input  logic [NUM_WR*AW-1:0]   i_wr_addr,
    input  logic [NUM_WR*XLEN-1:0] i_wr_data,
    input  logic [NUM_RD*AW-1:0]   i_rd_addr,
    output logic [NUM_RD*XLEN-1:0] o_rd_data,
    output logic [NUM_RD-1:0]      o_rd_busy,
    input  logic                   i_issue_en,
    input  logic [AW-1:0]          i_issue_rd,
    output logic                   o_ready
);

    localparam logic [AW-1:0] C_LAST = AW'(DEPTH - 1);
    localparam bit            C_ZERO = (ZERO_REG != 0);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AW-1:0]    r_cnt;
    logic [XLEN-1:0]  r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_nxt;
    logic             w_run;
    logic [NUM_WR-1:0] w_wr_act;
    logic             w_iss_act;

    // ------------------------------------------------------------------
    // Control FSM: CLEAR walks the counter over every register once,
    // then the file stays in RUN until the next reset.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (r_cnt == C_LAST) w_state_nxt = ST_RUN;
            ST_RUN:   w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_CLEAR;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_cnt <= r_cnt + AW'(1);
        end
    end

    assign w_run   = (r_state == ST_RUN);
    assign o_ready = w_run;

    // ------------------------------------------------------------------
    // Qualified write / issue strobes. Writes and issues are suppressed in
    // CLEAR, in a reset cycle, and for register 0 when it is hard-wired.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
        assign w_wr_act[k] = w_run && !i_rst && i_wr_en[k] &&
                             !(C_ZERO && (i_wr_addr[k*AW +: AW] == '0));
    end

    assign w_iss_act = w_run && !i_rst && i_issue_en &&
                       !(C_ZERO && (i_issue_rd == '0));

    // ------------------------------------------------------------------
    // Storage array. Later loop iterations override earlier ones, so the
    // highest-index port wins an address conflict.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!w_run) begin
            r_mem[r_cnt] <= '0;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (w_wr_act[k]) begin
                    r_mem[i_wr_addr[k*AW +: AW]] <= i_wr_data[k*XLEN +: XLEN];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Busy scoreboard: writebacks clear, issue sets afterwards so that a
    // same-cycle issue (new producer) supersedes the completing write.
    // ------------------------------------------------------------------
    always_comb begin
        w_busy_nxt = r_busy;
        for (int k = 0; k < NUM_WR; k++) begin
            if (w_wr_act[k]) w_busy_nxt[i_wr_addr[k*AW +: AW]] = 1'b0;
        end
        if (w_iss_act) w_busy_nxt[i_issue_rd] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Combinational read ports.
    // ------------------------------------------------------------------
    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_data;
        logic            w_bsy;

        assign w_ra = i_rd_addr[j*AW +: AW];

        always_comb begin
            w_data = r_mem[w_ra];
            w_bsy  = r_busy[w_ra];
`ifdef REGFILE_BYPASS_EN
            // w_wr_act is already qualified by RUN and register 0.
            for (int k = 0; k < NUM_WR; k++) begin
                if (w_wr_act[k] && (i_wr_addr[k*AW +: AW] == w_ra)) begin
                    w_data = i_wr_data[k*XLEN +: XLEN];
                    w_bsy  = (w_iss_act && (i_issue_rd == w_ra)) ? r_busy[w_ra] : 1'b0;
                end
            end
`endif
            if (!w_run || (C_ZERO && (w_ra == '0))) begin
                w_data = '0;
                w_bsy  = 1'b0;
            end
        end

        assign o_rd_data[j*XLEN +: XLEN] = w_data;
        assign o_rd_busy[j]              = w_bsy;
    end

endmodule
`default_nettype wire
